// File: rtl/pwm_dac_if.sv
// Sample handshake and PWM status bundle between the AM stage and the PWM DAC.
// The master side supplies samples and enable; the slave side is the DAC.
interface pwm_dac_if #(
  parameter int WIDTH       = 7,
  parameter int COUNT_WIDTH = 7
);
  logic                   enable;
  logic [WIDTH-1:0]       duty_cycle;
  logic                   duty_valid;
  logic                   duty_ready;
  logic                   pwm_out;
  logic                   zero;
  logic                   underrun;
  logic [COUNT_WIDTH-1:0] count_value;

  modport master (
    output enable, duty_cycle, duty_valid,
    input  duty_ready, pwm_out, zero, underrun, count_value
  );

  modport slave (
    input  enable, duty_cycle, duty_valid,
    output duty_ready, pwm_out, zero, underrun, count_value
  );
endinterface

// File: rtl/pwm_dac_buffered.sv
// PWM DAC with a one-deep shadow register; new duty values are loaded only at
// period wraps so pulses are never truncated. zero marks each period start.
module pwm_dac_buffered #(
  parameter int WIDTH       = 7,
  parameter int COUNT_WIDTH = 7,
  parameter int MAX_COUNT   = 127
) (
  input logic     clk,
  input logic     reset,
  pwm_dac_if.slave bus
);

  localparam int CMP_WIDTH = (WIDTH > COUNT_WIDTH) ? WIDTH : COUNT_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] TERMINAL = COUNT_WIDTH'(MAX_COUNT);

  logic [COUNT_WIDTH-1:0] count;
  logic [WIDTH-1:0]       shadow;
  logic                   shadow_full;
  logic [WIDTH-1:0]       active_duty;
  logic                   pwm_q;
  logic                   zero_q;
  logic                   underrun_q;

  logic                   wrap;
  logic                   accept;
  logic [CMP_WIDTH-1:0]   count_ext;
  logic [CMP_WIDTH-1:0]   duty_ext;

  assign wrap      = bus.enable && (count == TERMINAL);
  assign accept    = bus.duty_valid && !shadow_full;
  assign count_ext = CMP_WIDTH'(count);
  assign duty_ext  = CMP_WIDTH'(active_duty);

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      active_duty <= '0;
      pwm_q       <= 1'b0;
      zero_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      if (bus.enable) begin
        count <= wrap ? '0 : count + COUNT_WIDTH'(1);
        pwm_q <= (count_ext < duty_ext);
      end
      zero_q     <= wrap;
      underrun_q <= wrap && !shadow_full;
      // Accept can only coincide with a wrap when the shadow is empty, so the
      // transfer and the load never compete for the shadow register.
      if (wrap && shadow_full) begin
        active_duty <= shadow;
        shadow_full <= 1'b0;
      end else if (accept) begin
        shadow      <= bus.duty_cycle;
        shadow_full <= 1'b1;
      end
    end
  end

  assign bus.duty_ready  = !shadow_full;
  assign bus.pwm_out     = pwm_q;
  assign bus.zero        = zero_q;
  assign bus.underrun    = underrun_q;
  assign bus.count_value = count;

endmodule

// File: tb/tb_pwm_dac_buffered.sv
// Directed bench for pwm_dac_buffered: idle underruns, handshake, duty streaming,
// wrap-coincident accept, enable freeze and mid-period reset.
module tb_pwm_dac_buffered;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // 8-bit duty so that a value above the terminal count (200) is representable.
  pwm_dac_if #(.WIDTH(8), .COUNT_WIDTH(7)) bus ();

  pwm_dac_buffered #(.WIDTH(8), .COUNT_WIDTH(7), .MAX_COUNT(127)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles; duty_valid is held only for the first edge. Returns the
  // number of sampled cycles with pwm_out high.
  task automatic run(input int n, output int high);
    high = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.duty_valid = 1'b0;
      if (bus.pwm_out === 1'b1) high++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int h, h1, h2;
    int e_pwm, e_rdy, e_und, e_zero, e_cnt, fz;
    logic [7:0] vals [4];
    int         exp_h [4];

    reset          = 1'b1;
    bus.enable     = 1'b1;
    bus.duty_valid = 1'b0;
    bus.duty_cycle = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_count",    32'(bus.count_value), 0);
    check("reset_pwm",      32'(bus.pwm_out), 0);
    check("reset_zero",     32'(bus.zero), 0);
    check("reset_underrun", 32'(bus.underrun), 0);
    check("reset_ready",    32'(bus.duty_ready), 1);
    reset = 1'b0;

    // Idle: no samples for 300 cycles.
    e_pwm = 0; e_rdy = 0; e_und = 0; e_zero = 0; e_cnt = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (bus.pwm_out !== 1'b0) e_pwm++;
      if (bus.duty_ready !== 1'b1) e_rdy++;
      if (bus.underrun !== ((n == 128) || (n == 256))) e_und++;
      if (bus.zero !== ((n == 128) || (n == 256))) e_zero++;
      if (bus.count_value !== 7'(n % 128)) e_cnt++;
    end
    check("idle_pwm_errs",      e_pwm, 0);
    check("idle_ready_errs",    e_rdy, 0);
    check("idle_underrun_errs", e_und, 0);
    check("idle_zero_errs",     e_zero, 0);
    check("idle_count_errs",    e_cnt, 0);

    // Accept 32 at cycle 5.
    do_reset();
    run(5, h);
    bus.duty_valid = 1'b1;
    bus.duty_cycle = 8'd32;
    run(1, h);
    check("acc_ready_low_c6", 32'(bus.duty_ready), 0);
    run(121, h);
    check("acc_count_c127",    32'(bus.count_value), 127);
    check("acc_ready_low_c127", 32'(bus.duty_ready), 0);
    run(1, h);
    check("acc_wrap_count",    32'(bus.count_value), 0);
    check("acc_wrap_zero",     32'(bus.zero), 1);
    check("acc_wrap_underrun", 32'(bus.underrun), 0);
    check("acc_wrap_ready",    32'(bus.duty_ready), 1);
    run(1, h1);
    check("acc_first_pulse", h1, 1);
    run(127, h2);
    check("acc_high_32", h1 + h2, 32);
    check("acc_next_underrun", 32'(bus.underrun), 1);

    // Stream one sample per period; each shows up one period later.
    vals[0] = 8'd0;  vals[1] = 8'd64; vals[2] = 8'd127; vals[3] = 8'd200;
    exp_h[0] = 32;   exp_h[1] = 0;    exp_h[2] = 64;    exp_h[3] = 127;
    for (int i = 0; i < 4; i++) begin
      bus.duty_valid = 1'b1;
      bus.duty_cycle = vals[i];
      run(128, h);
      check($sformatf("stream_high_%0d", i), h, exp_h[i]);
      check($sformatf("stream_underrun_%0d", i), 32'(bus.underrun), 0);
      check($sformatf("stream_zero_%0d", i), 32'(bus.zero), 1);
    end
    run(128, h);
    check("stream_high_200", h, 128);
    check("stream_end_underrun", 32'(bus.underrun), 1);

    // Sample presented exactly on the wrap cycle with the shadow empty.
    run(127, h1);
    check("wrapacc_count", 32'(bus.count_value), 127);
    bus.duty_valid = 1'b1;
    bus.duty_cycle = 8'd16;
    run(1, h2);
    check("wrapacc_prev_high", h1 + h2, 128);
    check("wrapacc_underrun",  32'(bus.underrun), 1);
    check("wrapacc_zero",      32'(bus.zero), 1);
    check("wrapacc_ready",     32'(bus.duty_ready), 0);
    run(128, h);
    check("wrapacc_repeat_old", h, 128);
    check("wrapacc_xfer_underrun", 32'(bus.underrun), 0);
    check("wrapacc_xfer_ready", 32'(bus.duty_ready), 1);
    run(128, h);
    check("wrapacc_new_high", h, 16);

    // Enable freeze mid-pulse with duty 64; a sample arrives during the freeze.
    bus.duty_valid = 1'b1;
    bus.duty_cycle = 8'd64;
    run(128, h);
    check("frz_prev_high", h, 16);
    run(20, h1);
    check("frz_pwm_before", 32'(bus.pwm_out), 1);
    bus.enable = 1'b0;
    fz = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        bus.duty_valid = 1'b1;
        bus.duty_cycle = 8'd100;
      end
      @(posedge clk);
      #1;
      bus.duty_valid = 1'b0;
      if (bus.count_value !== 7'd20) fz++;
      if (bus.pwm_out !== 1'b1) fz++;
      if (bus.zero !== 1'b0) fz++;
      if (bus.underrun !== 1'b0) fz++;
    end
    check("frz_hold_errs", fz, 0);
    check("frz_accept_ready", 32'(bus.duty_ready), 0);
    bus.enable = 1'b1;
    run(108, h2);
    check("frz_total_high", h1 + h2, 64);
    check("frz_end_zero", 32'(bus.zero), 1);
    check("frz_end_underrun", 32'(bus.underrun), 0);

    // Reset mid-period with duty 100 active and a sample pending.
    bus.duty_valid = 1'b1;
    bus.duty_cycle = 8'd5;
    run(60, h);
    check("rst_pre_ready", 32'(bus.duty_ready), 0);
    check("rst_pre_pwm",   32'(bus.pwm_out), 1);
    do_reset();
    check("rst_count",    32'(bus.count_value), 0);
    check("rst_pwm",      32'(bus.pwm_out), 0);
    check("rst_zero",     32'(bus.zero), 0);
    check("rst_underrun", 32'(bus.underrun), 0);
    check("rst_ready",    32'(bus.duty_ready), 1);
    run(128, h);
    check("rst_period1_high", h, 0);
    check("rst_period1_underrun", 32'(bus.underrun), 1);
    run(128, h);
    check("rst_period2_high", h, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
